pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter unit for the multi-cycle/pipelined datapath; successor to the single-register PC.
- Holds the PC and selects the next PC internally from sequential, branch, jump, register-jump, exception and return sources.
- Stores the exception return address (EPC).
- Optionally predicts returns with a small return-address stack (RAS).
- Feeds instruction fetch; the control unit drives the select/strobe inputs.

Parameters:
- WIDTH, 32, PC/address width in bits (>=8).
- RESET_VEC, 32'h0000_3000, PC value after reset.
- EXC_VEC, 32'h0000_4180, exception handler entry address.
- RAS_DEPTH, 4, return-address stack entries (power of 2, >=2); used only with PC_RAS_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_write  in  1  1 = update PC this cycle; 0 = stall (hold).
- br_taken  in  1  conditional branch taken.
- br_target  in  WIDTH  branch target.
- jump  in  1  absolute jump.
- jump_target  in  WIDTH  jump target.
- jr  in  1  register jump.
- jr_target  in  WIDTH  register value for jr/ret fallback.
- call  in  1  current instruction is a call (link).
- ret  in  1  current instruction is a return (jr to link register).
- exc  in  1  exception request.
- eret  in  1  return from exception.
- pc  out  WIDTH  current PC.
- pc_plus4  out  WIDTH  pc + 4, combinational, mod 2^WIDTH.
- epc  out  WIDTH  saved exception PC.
- pc_misalign  out  1  pc[1:0] != 0, combinational from pc.
- ras_empty  out  1  RAS holds 0 entries; tied 1 without PC_RAS_EN.
- ras_underflow  out  1  registered one-cycle pulse: ret found RAS empty.

Behaviour:
- Reset (async): pc=RESET_VEC, epc=0, RAS count=0, RAS pointer=0, ras_underflow=0. Reset mid-operation discards everything immediately.
- Next-PC priority, highest first:
  - exc: EXC_VEC
  - eret: epc
  - ret: RAS top / jr_target
  - jr: jr_target
  - jump: jump_target
  - br_taken: br_target
  - otherwise: pc_plus4
- exc and eret take effect regardless of pc_write. All other sources update pc only when pc_write=1; when pc_write=0, pc, RAS and epc hold.
- exc: epc <= pc (address of faulting instruction) on the same edge that pc <= EXC_VEC. exc takes precedence over a simultaneous eret; epc is overwritten.
- eret: pc <= epc; epc unchanged.
- Latency: the selected next PC appears on pc one edge after the inputs are sampled. pc_plus4 is valid in the same cycle.
- Targets are used unmodified. Misaligned values propagate and are flagged on pc_misalign; no trap is raised internally.
- Wrap-around: pc_plus4 at 2^WIDTH-4 yields 0.
- RAS (with PC_RAS_EN), effective only on a pc_write=1 cycle with no exc/eret:
  - call alone: push pc_plus4; count saturates at RAS_DEPTH. When full, the oldest entry is overwritten (circular) and the pointer advances.
  - ret alone, count>0: next pc = top; pop; count-1.
  - ret alone, count==0: next pc = jr_target; ras_underflow=1 for one cycle.
  - call and ret together: next pc = top (or jr_target if empty); top is replaced with pc_plus4; count unchanged (or becomes 1 if it was empty).
- ras_underflow deasserts on the next edge unless re-triggered.

Optional Feature:
- PC_RAS_EN defined: RAS instantiated as above.
- Undefined: no RAS storage; ret behaves exactly as jr (next pc = jr_target); call is ignored; ras_empty=1; ras_underflow=0.

Test Plan:
- Reset, then pc_write=1 with no selects for 3 cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; assert rst mid-cycle -> pc=0x3000 immediately.
- pc=0x3010, pc_write=0, br_taken=1, br_target=0x3100 -> pc holds 0x3010; raise pc_write -> pc=0x3100; jump and br_taken together -> jump_target wins.
- pc=0x3020, pc_write=0, exc=1 -> pc=0x4180, epc=0x3020; later eret -> pc=0x3020; exc+eret same cycle -> pc=0x4180.
- PC_RAS_EN, RAS_DEPTH=4: call at 0x3000, 0x3100, 0x3200, 0x3300, 0x3400 -> ras count stays 4; 4 rets return 0x3404, 0x3304, 0x3204, 0x3104; 5th ret with jr_target=0x3AAC -> pc=0x3AAC, ras_underflow pulses once, ras_empty=1.
- PC_RAS_EN: RAS top=0x3204, call+ret at pc=0x3500 -> pc=0x3204, new top=0x3504, count unchanged.
- PC_RAS_EN undefined: ret with jr_target=0x3080 -> pc=0x3080, ras_empty=1; pc=0xFFFF_FFFC sequential -> pc=0x0000_0000.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: program counter with next-PC select, exception return address and optional return-address stack (PC_RAS_EN).
// Latency: selected next PC appears on pc one clk edge after sampling; pc_plus4/pc_misalign are combinational from pc.
// Backpressure: pc_write=0 stalls pc, epc and the RAS; exc and eret bypass the stall.
module pc_gen #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             call,
    input  logic             ret,
    input  logic             exc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic             pc_misalign,
    output logic             ras_empty,
    output logic             ras_underflow
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             ras_underflow_q, ras_underflow_d;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] ret_pc;     // destination chosen for a return

    assign seq_pc      = pc_q + WIDTH'(4);
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;
    assign epc         = epc_q;
    assign pc_misalign = (pc_q[1:0] != 2'b00);
    assign ras_underflow = ras_underflow_q;

`ifdef PC_RAS_EN
    localparam int               PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]   RAS_FULL = (PTR_W+1)'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;   // next free slot; top is one below
    logic [PTR_W:0]   ras_cnt_q, ras_cnt_d;
    logic [PTR_W-1:0] ras_top_idx;
    logic             ras_hit;
    logic             flow_upd;               // ordinary control-flow update, no exc/eret

    assign ras_top_idx = ras_ptr_q - PTR_W'(1);
    assign ras_hit     = (ras_cnt_q != '0);
    assign ret_pc      = ras_hit ? ras_mem_q[ras_top_idx] : jr_target;
    assign ras_empty   = ~ras_hit;
    assign flow_upd    = pc_write & ~exc & ~eret;

    // Stack maintenance: push on call, pop on ret, replace top on call+ret.
    always_comb begin
        ras_mem_d       = ras_mem_q;
        ras_ptr_d       = ras_ptr_q;
        ras_cnt_d       = ras_cnt_q;
        ras_underflow_d = 1'b0;
        if (flow_upd) begin
            if (call && ret) begin
                if (ras_hit) begin
                    ras_mem_d[ras_top_idx] = seq_pc;
                end else begin
                    ras_mem_d[ras_ptr_q] = seq_pc;
                    ras_ptr_d            = ras_ptr_q + PTR_W'(1);
                    ras_cnt_d            = (PTR_W+1)'(1);
                end
            end else if (call) begin
                // Full stack wraps over the oldest entry; count saturates.
                ras_mem_d[ras_ptr_q] = seq_pc;
                ras_ptr_d            = ras_ptr_q + PTR_W'(1);
                if (ras_cnt_q != RAS_FULL) begin
                    ras_cnt_d = ras_cnt_q + (PTR_W+1)'(1);
                end
            end else if (ret) begin
                if (ras_hit) begin
                    ras_ptr_d = ras_top_idx;
                    ras_cnt_d = ras_cnt_q - (PTR_W+1)'(1);
                end else begin
                    ras_underflow_d = 1'b1;
                end
            end
        end
    end

    // Stack storage, pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= '0;
            end
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_mem_q <= ras_mem_d;
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end
`else
    // Without the stack a return is a plain register jump and call has no effect.
    logic unused_ras;

    assign ret_pc          = jr_target;
    assign ras_empty       = 1'b1;
    assign ras_underflow_d = 1'b0;
    assign unused_ras      = ^{call, 32'(RAS_DEPTH)};
`endif

    // Next-PC priority: exc, eret, ret, jr, jump, branch, sequential.
    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        if (exc) begin
            pc_d  = EXC_VEC;
            epc_d = pc_q;
        end else if (eret) begin
            pc_d = epc_q;
        end else if (pc_write) begin
            if (ret) begin
                pc_d = ret_pc;
            end else if (jr) begin
                pc_d = jr_target;
            end else if (jump) begin
                pc_d = jump_target;
            end else if (br_taken) begin
                pc_d = br_target;
            end else begin
                pc_d = seq_pc;
            end
        end
    end

    // PC, EPC and underflow pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q            <= RESET_VEC;
            epc_q           <= '0;
            ras_underflow_q <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            epc_q           <= epc_d;
            ras_underflow_q <= ras_underflow_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed plus randomized checks of pc_gen against a queue-based reference model.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: pc_write is randomized to exercise stalls.
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;
    localparam int          RAS_N  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write, br_taken, jump, jr, call, ret, exc, eret;
    logic [31:0] br_target, jump_target, jr_target;
    logic [31:0] pc, pc_plus4, epc;
    logic        pc_misalign, ras_empty, ras_underflow;

    always #5 clk = ~clk;

    pc_gen #(
        .WIDTH    (32),
        .RESET_VEC(RST_PC),
        .EXC_VEC  (EXC_PC),
        .RAS_DEPTH(RAS_N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_write     (pc_write),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_target    (jr_target),
        .call         (call),
        .ret          (ret),
        .exc          (exc),
        .eret         (eret),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .epc          (epc),
        .pc_misalign  (pc_misalign),
        .ras_empty    (ras_empty),
        .ras_underflow(ras_underflow)
    );

    int tests = 0;
    int fails = 0;

    // Reference state: architectural PC/EPC and the return stack as a bounded queue (back = top).
    logic [31:0] m_pc, m_epc;
    logic        m_uf;
    logic [31:0] m_ras[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = RST_PC;
        m_epc = 32'h0;
        m_uf  = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_step();
        logic [31:0] p4;
        logic [31:0] nxt;
        p4   = m_pc + 32'd4;
        nxt  = p4;
        m_uf = 1'b0;
        if (exc) begin
            m_epc = m_pc;
            m_pc  = EXC_PC;
        end else if (eret) begin
            m_pc = m_epc;
        end else if (pc_write) begin
            if (ret) begin
`ifdef PC_RAS_EN
                nxt = (m_ras.size() > 0) ? m_ras[$] : jr_target;
                if (call) begin
                    if (m_ras.size() > 0) m_ras[m_ras.size()-1] = p4;
                    else m_ras.push_back(p4);
                end else if (m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end else begin
                    m_uf = 1'b1;
                end
`else
                nxt = jr_target;
`endif
            end else if (jr)       nxt = jr_target;
            else if (jump)         nxt = jump_target;
            else if (br_taken)     nxt = br_target;
            else                   nxt = p4;
`ifdef PC_RAS_EN
            if (call && !ret) begin
                m_ras.push_back(p4);
                if (m_ras.size() > RAS_N) void'(m_ras.pop_front());
            end
`endif
            m_pc = nxt;
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_empty;
`ifdef PC_RAS_EN
        exp_empty = (m_ras.size() == 0);
`else
        exp_empty = 1'b1;
`endif
        chk({tag, ".pc"},        pc,                   m_pc);
        chk({tag, ".epc"},       epc,                  m_epc);
        chk({tag, ".pc_plus4"},  pc_plus4,             m_pc + 32'd4);
        chk({tag, ".misalign"},  32'(pc_misalign),     32'(m_pc[1:0] != 2'b00));
        chk({tag, ".ras_empty"}, 32'(ras_empty),       32'(exp_empty));
        chk({tag, ".underflow"}, 32'(ras_underflow),   32'(m_uf));
    endtask

    task automatic clr();
        pc_write = 1'b0; br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        call = 1'b0; ret = 1'b0; exc = 1'b0; eret = 1'b0;
        br_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        clr();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_pc", pc, 32'h0000_3000);
        rst = 1'b0;

        // Sequential flow.
        pc_write = 1'b1;
        tick("seq1"); chk("seq1_pc", pc, 32'h0000_3004);
        tick("seq2"); chk("seq2_pc", pc, 32'h0000_3008);
        tick("seq3"); chk("seq3_pc", pc, 32'h0000_300C);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_pc", pc, 32'h0000_3000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("after_rst");

        // Stall and branch/jump priority.
        clr(); pc_write = 1'b1; jump = 1'b1; jump_target = 32'h0000_3010;
        tick("to3010");
        clr(); br_taken = 1'b1; br_target = 32'h0000_3100;
        tick("stall"); chk("stall_pc", pc, 32'h0000_3010);
        pc_write = 1'b1;
        tick("br"); chk("br_pc", pc, 32'h0000_3100);
        jump = 1'b1; jump_target = 32'h0000_3200;
        tick("jmp_br"); chk("jmp_over_br", pc, 32'h0000_3200);

        // Exception entry during a stall, eret, and exc+eret together.
        clr(); pc_write = 1'b1; jump = 1'b1; jump_target = 32'h0000_3020;
        tick("to3020");
        clr(); exc = 1'b1;
        tick("exc"); chk("exc_pc", pc, 32'h0000_4180); chk("exc_epc", epc, 32'h0000_3020);
        clr(); pc_write = 1'b1;
        tick("handler");
        clr(); eret = 1'b1;
        tick("eret"); chk("eret_pc", pc, 32'h0000_3020);
        exc = 1'b1;
        tick("exc_eret"); chk("exc_eret_pc", pc, 32'h0000_4180);

        // Misaligned target and address wrap.
        clr(); pc_write = 1'b1; jump = 1'b1; jump_target = 32'h0000_3002;
        tick("misalign"); chk("misalign_flag", 32'(pc_misalign), 32'd1);
        jump_target = 32'hFFFF_FFFC;
        tick("to_top");
        clr(); pc_write = 1'b1;
        tick("wrap"); chk("wrap_pc", pc, 32'h0000_0000);

`ifdef PC_RAS_EN
        // Five calls into a four-entry stack, then drain past empty.
        clr(); pc_write = 1'b1; jump = 1'b1; jump_target = 32'h0000_3000;
        tick("ras_start");
        for (int k = 0; k < 5; k++) begin
            clr(); pc_write = 1'b1; call = 1'b1; jump = 1'b1;
            jump_target = (k == 4) ? 32'h0000_3600 : 32'h0000_3100 + 32'(k) * 32'h100;
            tick("ras_call");
        end
        chk("ras_not_empty", 32'(ras_empty), 32'd0);
        clr(); pc_write = 1'b1; ret = 1'b1; jr_target = 32'h0000_3AAC;
        tick("ret1"); chk("ret1_pc", pc, 32'h0000_3404);
        tick("ret2"); chk("ret2_pc", pc, 32'h0000_3304);
        tick("ret3"); chk("ret3_pc", pc, 32'h0000_3204);
        tick("ret4"); chk("ret4_pc", pc, 32'h0000_3104);
        tick("ret5"); chk("ret5_pc", pc, 32'h0000_3AAC);
        chk("uf_pulse", 32'(ras_underflow), 32'd1);
        chk("uf_empty", 32'(ras_empty), 32'd1);
        clr(); pc_write = 1'b1;
        tick("uf_drop"); chk("uf_clear", 32'(ras_underflow), 32'd0);

        // call+ret replaces the top entry.
        clr(); pc_write = 1'b1; jump = 1'b1; jump_target = 32'h0000_3200;
        tick("to3200");
        clr(); pc_write = 1'b1; call = 1'b1; jump = 1'b1; jump_target = 32'h0000_3500;
        tick("call3200");
        clr(); pc_write = 1'b1; call = 1'b1; ret = 1'b1; jr_target = 32'h0000_3AAC;
        tick("callret"); chk("callret_pc", pc, 32'h0000_3204);
        clr(); pc_write = 1'b1; ret = 1'b1; jr_target = 32'h0000_3AAC;
        tick("new_top"); chk("new_top_pc", pc, 32'h0000_3504);
`else
        // Return without a stack is a register jump.
        clr(); pc_write = 1'b1; ret = 1'b1; call = 1'b1; jr_target = 32'h0000_3080;
        tick("ret_jr"); chk("ret_jr_pc", pc, 32'h0000_3080);
        chk("no_ras_empty", 32'(ras_empty), 32'd1);
        chk("no_ras_uf", 32'(ras_underflow), 32'd0);
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                check_all("rnd_rst");
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            pc_write    = ($urandom_range(3) != 0);
            br_taken    = ($urandom_range(3) == 0);
            jump        = ($urandom_range(5) == 0);
            jr          = ($urandom_range(7) == 0);
            call        = ($urandom_range(4) == 0);
            ret         = ($urandom_range(4) == 0);
            exc         = ($urandom_range(31) == 0);
            eret        = ($urandom_range(31) == 0);
            br_target   = $urandom & (($urandom_range(15) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            jump_target = $urandom & 32'hFFFF_FFFC;
            jr_target   = $urandom & (($urandom_range(15) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
